// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-requester data-memory arbiter.
// Owner and FSM state values are fixed so both files and the bench agree.
package mem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Purpose: two-way round-robin pick; the requester that was not last served wins a tie.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether a pick is honoured this cycle.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant0,
    output logic grant1
);

    // last=1 means requester 1 was served most recently, so requester 0 has priority.
    assign grant0 = req0 & (~req1 | last);
    assign grant1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port data memory between the CPU and a loader/debug port.
// Latency: writes complete in the grant cycle; read data returns one cycle after grant.
// Backpressure: no grant while a read is outstanding; a requester holds its request until gnt.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t state, state_nxt;
    owner_t last_owner;
    logic   pick_cpu, pick_ldr;

    rr_pick2 u_pick (
        .req0   (cpu_req),
        .req1   (ldr_req),
        .last   (last_owner),
        .grant0 (pick_cpu),
        .grant1 (pick_ldr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= OWN_LDR;
        end else begin
            state <= state_nxt;
            if (cpu_gnt) begin
                last_owner <= OWN_CPU;
            end else if (ldr_gnt) begin
                last_owner <= OWN_LDR;
            end
        end
    end

    // In RD_WAIT, last_owner still names the requester whose read is in flight.
    always_comb begin
        state_nxt  = state;
        cpu_gnt    = 1'b0;
        ldr_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        ldr_rvalid = 1'b0;
        cpu_rdata  = '0;
        ldr_rdata  = '0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (pick_cpu) begin
                        cpu_gnt   = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        if (!cpu_we) state_nxt = RD_WAIT;
                    end else if (pick_ldr) begin
                        ldr_gnt   = 1'b1;
                        mem_we    = ldr_we;
                        mem_addr  = ldr_addr;
                        mem_wdata = ldr_wdata;
                        if (!ldr_we) state_nxt = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (last_owner == OWN_CPU) begin
                        cpu_rvalid = 1'b1;
                        cpu_rdata  = mem_rdata;
                    end else begin
                        ldr_rvalid = 1'b1;
                        ldr_rdata  = mem_rdata;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width in bits.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  is the synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-005 Ports cpu_req / cpu_we  input  1 / 1  are the processor data-port request and write-enable.
REQ-006 Ports cpu_addr / cpu_wdata  input  AW / DW  are the processor address and write data.
REQ-007 Ports cpu_gnt / cpu_rvalid  output  1 / 1  are the access-accepted pulse and the read-data-valid pulse.
REQ-008 Port cpu_rdata  output  DW  is the processor read data.
REQ-009 Ports ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid and ldr_rdata SHALL mirror REQ-005..008 for the loader/debug requester.
REQ-010 Ports mem_we  output  1, mem_addr  output  AW and mem_wdata  output  DW form the single-port data memory command.
REQ-011 Port mem_rdata  input  DW  is the memory read data, valid exactly one cycle after the read address is presented.
REQ-012 Port cpu_stall  output  1  SHALL equal cpu_req AND NOT cpu_gnt, combinationally.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and RD_WAIT.
REQ-014 In IDLE with at least one request pending, the block SHALL grant exactly one requester that cycle: gnt high for 1 cycle, and mem_addr, mem_we and mem_wdata driven combinationally from the granted requester.
REQ-015 Arbitration SHALL be round-robin on a 1-bit last_owner register: on a simultaneous request, the requester that is not last_owner wins.
REQ-016 last_owner SHALL update to the granted requester on every grant.
REQ-017 A granted write SHALL complete in its grant cycle: mem_we=1, no rvalid, and the FSM stays in IDLE.
REQ-018 A granted read SHALL move the FSM to RD_WAIT.
REQ-019 In RD_WAIT, the owner's rvalid SHALL be high for exactly 1 cycle, its rdata SHALL equal mem_rdata, no grant SHALL be issued, and the FSM SHALL return to IDLE.
REQ-020 Read latency SHALL be 1 cycle from grant; maximum throughput SHALL be one write per cycle or one read per 2 cycles.
REQ-021 Requesters SHALL hold req, we, addr and wdata stable until gnt; a req drop before gnt is a legal cancellation with no memory effect.
REQ-022 When no grant is issued, mem_we SHALL be 0; mem_addr and mem_wdata are don't-care but SHALL be driven to 0.
REQ-023 rdata of the non-owner SHALL be 0.
REQ-024 Back-to-back requests from one requester with the other idle SHALL be granted every eligible cycle with no bubble, except the RD_WAIT cycle.
REQ-025 Starvation bound: under continuous contention, each requester SHALL be granted at least once every 2 grants.

Reset
REQ-026 While reset=1, the FSM SHALL enter IDLE and last_owner SHALL be set to LDR, so the CPU wins the first contention.
REQ-027 While reset=1, all gnt, rvalid and mem_we outputs SHALL be 0 and all rdata outputs SHALL be 0.
REQ-028 Reset asserted during RD_WAIT SHALL abort the read: no rvalid is issued after reset.

Structure
REQ-029 The owner encoding (CPU=0, LDR=1) and the FSM state encoding (IDLE=0, RD_WAIT=1) SHALL live in shared package mem_arb_pkg.
REQ-030 The fairness pointer SHALL be a sub-module rr_pick2 (inputs req0, req1, last; outputs grant0, grant1), purely combinational.
REQ-031 The FSM and last_owner registers SHALL be in mem_arbiter, with no other sequential sub-modules.

Verification
REQ-032 Reset release, then cpu_req read of addr 0x10 with mem holding 0xDEADBEEF -> cpu_gnt at cycle 0, cpu_rvalid with cpu_rdata=0xDEADBEEF at cycle 1.
REQ-033 cpu and ldr both write in the same cycle after reset (addr 0x4/0x8, data 0x11/0x22) -> CPU granted first, LDR the next cycle; mem shows 0x11@0x4 and 0x22@0x8.
REQ-034 Continuous contention of reads from both requesters for 8 grants -> grants alternate CPU, LDR, CPU, ..., with rvalid one cycle after each grant and no grant during RD_WAIT.
REQ-035 ldr reading 0x20 with reset asserted in RD_WAIT -> no ldr_rvalid, FSM in IDLE, outputs 0.
REQ-036 cpu_req asserted while the LDR read is in RD_WAIT -> cpu_stall=1 for that cycle, cpu_gnt the next cycle.
REQ-037 ldr_req raised and dropped before grant (blocked by a CPU read) -> no mem_we and no ldr_gnt.
